// File: rtl/step_cmd_gen_pkg.sv
// -----------------------------------------------------------------------------
// step_cmd_gen_pkg
//   Shared constants and types for the step command generator.
//   The distributor and this block both derive their timing from CLK_HZ,
//   so changing the system clock means editing one number.
// -----------------------------------------------------------------------------
package step_cmd_gen_pkg;

    localparam int CLK_HZ       = 50_000_000;
    localparam int DEF_STEP_DIV = CLK_HZ;        // 1 step per second
    localparam int DEF_DEB_CYC  = CLK_HZ / 50;   // 20 ms of stable button level

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/step_cmd_gen_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//   2-FF synchronizer followed by a counting debouncer for one raw button.
//
// Ports
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   btn_raw  : raw, asynchronous button level
//   level    : debounced level; moves only after DEB_CYC equal samples
//   settled  : high once any level has been accepted since reset, i.e. the
//              debounced level reflects the real button rather than the
//              reset default
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEB_CYC = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic settled
);

    localparam int CW = $clog2(DEB_CYC + 1);

    logic          sync1_q,   sync1_d;
    logic          sync2_q,   sync2_d;
    logic          vld1_q,    vld1_d;
    logic          vld2_q,    vld2_d;
    logic          cand_q,    cand_d;
    logic [CW-1:0] cnt_q,     cnt_d;
    logic          level_q,   level_d;
    logic          settled_q, settled_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        sync1_d   = btn_raw;
        sync2_d   = sync1_q;
        vld1_d    = 1'b1;
        vld2_d    = vld1_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        settled_d = settled_q;

        // The valid pipeline masks the reset values still sitting in the
        // synchronizer, so a button held through reset is never mistaken
        // for a released one.
        if (vld2_q) begin
            if (sync2_q != cand_q) begin
                cand_d = sync2_q;
                cnt_d  = CW'(1);
            end else if (cnt_q != CW'(DEB_CYC)) begin
                cnt_d = cnt_q + CW'(1);
            end
            if (cnt_d == CW'(DEB_CYC)) begin
                level_d   = cand_d;
                settled_d = 1'b1;
            end
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            vld1_q    <= 1'b0;
            vld2_q    <= 1'b0;
            cand_q    <= 1'b0;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            settled_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            vld1_q    <= vld1_d;
            vld2_q    <= vld2_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            settled_q <= settled_d;
        end
    end

    assign level   = level_q;
    assign settled = settled_q;

endmodule

// File: rtl/step_cmd_gen.sv
// -----------------------------------------------------------------------------
// step_cmd_gen
//   Counted, abortable step command generator feeding the stepper pulse
//   distributor. Debounces START/STOP, latches N and DIR at move start and
//   emits N evenly spaced single-cycle STEP strobes.
//
// Ports
//   CP     : system clock
//   CR     : asynchronous active-low reset
//   START  : raw START button (active-high, asynchronous)
//   STOP   : raw STOP button (active-high, asynchronous)
//   DIR    : requested direction, 1 = forward; sampled at move start
//   N      : requested step count; sampled at move start
//   STEP   : one-cycle advance strobe
//   M      : latched direction, constant for the whole move
//   BUSY   : move in progress
//   DONE   : one-cycle pulse on normal completion (or on a zero-count start)
//   REMAIN : steps still to issue
// -----------------------------------------------------------------------------
module step_cmd_gen
    import step_cmd_gen_pkg::*;
#(
    parameter int STEP_DIV = DEF_STEP_DIV,
    parameter int DEB_CYC  = DEF_DEB_CYC,
    parameter int CNT_W    = 8
) (
    input  logic             CP,
    input  logic             CR,
    input  logic             START,
    input  logic             STOP,
    input  logic             DIR,
    input  logic [CNT_W-1:0] N,
    output logic             STEP,
    output logic             M,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] REMAIN
);

    localparam int PW = $clog2(STEP_DIV);

    logic start_lv, start_settled;
    logic stop_lv,  stop_settled;
    logic start_ev;

    state_e           state_q,      state_d;
    logic [PW-1:0]    presc_q,      presc_d;
    logic [CNT_W-1:0] remain_q,     remain_d;
    logic             m_q,          m_d;
    logic             step_q,       step_d;
    logic             done_q,       done_d;
    logic             busy_q,       busy_d;
    logic             start_prev_q, start_prev_d;
    logic             armed_q,      armed_d;

    btn_debounce #(.DEB_CYC(DEB_CYC)) u_start_deb (
        .clk     (CP),
        .rst_n   (CR),
        .btn_raw (START),
        .level   (start_lv),
        .settled (start_settled)
    );

    btn_debounce #(.DEB_CYC(DEB_CYC)) u_stop_deb (
        .clk     (CP),
        .rst_n   (CR),
        .btn_raw (STOP),
        .level   (stop_lv),
        .settled (stop_settled)
    );

    // Starts are accepted only after START has been seen released with both
    // button paths settled; a START held through reset therefore needs a
    // fresh press, and stop_lv is trustworthy before any move can begin.
    assign start_ev = start_lv & ~start_prev_q & armed_q;

    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        remain_d     = remain_q;
        m_d          = m_q;
        step_d       = 1'b0;
        done_d       = 1'b0;
        start_prev_d = start_lv;
        armed_d      = armed_q | (start_settled & stop_settled & ~start_lv);

        unique case (state_q)
            IDLE: begin
                if (start_ev && !stop_lv) begin
                    if (N != '0) begin
                        m_d      = DIR;
                        remain_d = N;
                        presc_d  = '0;
                        state_d  = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                // STOP takes priority over a coincident terminal count.
                if (stop_lv) begin
                    state_d = IDLE;
                end else if (presc_q == PW'(STEP_DIV - 1)) begin
                    step_d   = 1'b1;
                    remain_d = remain_q - CNT_W'(1);
                    presc_d  = '0;
                    if (remain_q == CNT_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // BUSY stays high through the final STEP/DONE cycle and drops after.
        busy_d = (state_d == RUN) || ((state_q == RUN) && done_d);
    end

    always_ff @(posedge CP or negedge CR) begin
        if (!CR) begin
            state_q      <= IDLE;
            presc_q      <= '0;
            remain_q     <= '0;
            m_q          <= 1'b1;
            step_q       <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            start_prev_q <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            remain_q     <= remain_d;
            m_q          <= m_d;
            step_q       <= step_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            start_prev_q <= start_prev_d;
            armed_q      <= armed_d;
        end
    end

    assign STEP   = step_q;
    assign M      = m_q;
    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign REMAIN = remain_q;

endmodule

// File: tb/tb_step_cmd_gen.sv
// -----------------------------------------------------------------------------
// tb_step_cmd_gen
//   Directed bench for step_cmd_gen with STEP_DIV=4, DEB_CYC=3, CNT_W=8.
//   Inputs are driven and outputs sampled 1 time unit after the falling edge.
// -----------------------------------------------------------------------------
module tb_step_cmd_gen;

    localparam int STEP_DIV = 4;
    localparam int DEB_CYC  = 3;
    localparam int CNT_W    = 8;
    // raw edge -> 2 sync flops -> DEB_CYC samples -> FSM register
    localparam int START_LAT = 2 + DEB_CYC + 1;

    logic             CP    = 1'b0;
    logic             CR    = 1'b0;
    logic             START = 1'b0;
    logic             STOP  = 1'b0;
    logic             DIR   = 1'b0;
    logic [CNT_W-1:0] N     = '0;
    logic             STEP, M, BUSY, DONE;
    logic [CNT_W-1:0] REMAIN;

    int total = 0;
    int bad   = 0;

    int step_tot = 0, done_tot = 0, busy_tot = 0, stray_step = 0;

    int w_steps, w_done, w_done_off, w_end_off, w_space_bad, w_rem_bad, w_m_bad;

    step_cmd_gen #(
        .STEP_DIV (STEP_DIV),
        .DEB_CYC  (DEB_CYC),
        .CNT_W    (CNT_W)
    ) dut (
        .CP     (CP),
        .CR     (CR),
        .START  (START),
        .STOP   (STOP),
        .DIR    (DIR),
        .N      (N),
        .STEP   (STEP),
        .M      (M),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .REMAIN (REMAIN)
    );

    always #5 CP = ~CP;

    // Running event counters; tasks compare deltas of these.
    always @(negedge CP) begin
        if (CR) begin
            if (STEP === 1'b1) step_tot++;
            if (DONE === 1'b1) done_tot++;
            if (BUSY === 1'b1) busy_tot++;
            if (STEP === 1'b1 && BUSY !== 1'b1) stray_step++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge CP);
            #1;
        end
    endtask

    task automatic press_wait(output int lat);
        START = 1'b1;
        lat   = -1;
        for (int i = 1; i <= 30; i++) begin
            tick(1);
            if (BUSY === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic release_buttons();
        START = 1'b0;
        STOP  = 1'b0;
        tick(10);
    endtask

    // Follows a move from the sample where BUSY was first seen (offset 0)
    // until BUSY drops. Optionally raises STOP at stop_off, and at chg_off
    // releases START, flips DIR, changes N, then re-presses START 6 later.
    task automatic watch_move(input int n0, input logic m_exp,
                              input int stop_off, input int chg_off);
        int off;
        off = 0;
        w_steps = 0; w_done = 0; w_done_off = -1;
        w_space_bad = 0; w_rem_bad = 0; w_m_bad = 0;
        while (BUSY === 1'b1 && off < 400) begin
            if (off == stop_off) STOP = 1'b1;
            if (chg_off >= 0 && off == chg_off) begin
                START = 1'b0;
                DIR   = ~DIR;
                N     = N + 8'd5;
            end
            if (chg_off >= 0 && off == chg_off + 6) START = 1'b1;
            tick(1);
            off++;
            if (STEP === 1'b1) begin
                w_steps++;
                if (off != STEP_DIV * w_steps) w_space_bad++;
            end
            if (DONE === 1'b1) begin
                w_done++;
                w_done_off = off;
            end
            if (BUSY === 1'b1) begin
                if (M !== m_exp) w_m_bad++;
                if (REMAIN !== 8'(n0 - w_steps)) w_rem_bad++;
            end
        end
        w_end_off = off;
    endtask

    task automatic test_reset();
        CR = 1'b0;
        tick(2);
        total++; if (STEP !== 1'b0) begin bad++; $display("FAIL reset_step: got %b want 0", STEP); end
        total++; if (DONE !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", DONE); end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", BUSY); end
        total++; if (M !== 1'b1) begin bad++; $display("FAIL reset_m: got %b want 1", M); end
        total++; if (REMAIN !== 8'd0) begin bad++; $display("FAIL reset_remain: got %0d want 0", REMAIN); end
        CR = 1'b1;
        tick(12);
    endtask

    task automatic test_normal_move();
        int lat;
        N = 8'd5; DIR = 1'b1;
        press_wait(lat);
        total++; if (lat !== START_LAT) begin bad++; $display("FAIL normal_latency: got %0d want %0d", lat, START_LAT); end
        total++; if (REMAIN !== 8'd5) begin bad++; $display("FAIL normal_remain_start: got %0d want 5", REMAIN); end
        watch_move(5, 1'b1, -1, -1);
        total++; if (w_steps !== 5) begin bad++; $display("FAIL normal_steps: got %0d want 5", w_steps); end
        total++; if (w_space_bad !== 0) begin bad++; $display("FAIL normal_spacing: got %0d bad gaps want 0", w_space_bad); end
        total++; if (w_rem_bad !== 0) begin bad++; $display("FAIL normal_remain_track: got %0d bad want 0", w_rem_bad); end
        total++; if (w_m_bad !== 0) begin bad++; $display("FAIL normal_m: got %0d bad want 0", w_m_bad); end
        total++; if (w_done !== 1) begin bad++; $display("FAIL normal_done_count: got %0d want 1", w_done); end
        total++; if (w_done_off !== 20) begin bad++; $display("FAIL normal_done_offset: got %0d want 20", w_done_off); end
        total++; if (w_end_off !== 21) begin bad++; $display("FAIL normal_busy_fall: got %0d want 21", w_end_off); end
        total++; if (REMAIN !== 8'd0) begin bad++; $display("FAIL normal_remain_end: got %0d want 0", REMAIN); end
        release_buttons();
    endtask

    task automatic test_reverse_move();
        int lat;
        N = 8'd2; DIR = 1'b0;
        press_wait(lat);
        watch_move(2, 1'b0, -1, -1);
        total++; if (w_steps !== 2) begin bad++; $display("FAIL reverse_steps: got %0d want 2", w_steps); end
        total++; if (w_m_bad !== 0) begin bad++; $display("FAIL reverse_m: got %0d bad want 0", w_m_bad); end
        total++; if (w_end_off !== 9) begin bad++; $display("FAIL reverse_busy_fall: got %0d want 9", w_end_off); end
        total++; if (M !== 1'b0) begin bad++; $display("FAIL reverse_m_hold: got %b want 0", M); end
        release_buttons();
    endtask

    task automatic test_zero_count();
        int s0, d0, b0;
        N = 8'd0; DIR = 1'b1;
        s0 = step_tot; d0 = done_tot; b0 = busy_tot;
        START = 1'b1;
        tick(12);
        total++; if (done_tot - d0 !== 1) begin bad++; $display("FAIL zero_done: got %0d want 1", done_tot - d0); end
        total++; if (step_tot - s0 !== 0) begin bad++; $display("FAIL zero_step: got %0d want 0", step_tot - s0); end
        total++; if (busy_tot - b0 !== 0) begin bad++; $display("FAIL zero_busy: got %0d want 0", busy_tot - b0); end
        release_buttons();
    endtask

    task automatic test_bounce();
        int d0, b0;
        N = 8'd3;
        d0 = done_tot; b0 = busy_tot;
        repeat (3) begin
            START = 1'b1; tick(2);
            START = 1'b0; tick(3);
        end
        tick(10);
        total++; if (busy_tot - b0 !== 0) begin bad++; $display("FAIL bounce_busy: got %0d want 0", busy_tot - b0); end
        total++; if (done_tot - d0 !== 0) begin bad++; $display("FAIL bounce_done: got %0d want 0", done_tot - d0); end
    endtask

    task automatic test_ignore_in_run();
        int lat, b0;
        N = 8'd4; DIR = 1'b0;
        press_wait(lat);
        watch_move(4, 1'b0, -1, 0);
        total++; if (w_steps !== 4) begin bad++; $display("FAIL ignore_steps: got %0d want 4", w_steps); end
        total++; if (w_m_bad !== 0) begin bad++; $display("FAIL ignore_m: got %0d bad want 0", w_m_bad); end
        total++; if (w_rem_bad !== 0) begin bad++; $display("FAIL ignore_remain: got %0d bad want 0", w_rem_bad); end
        total++; if (w_end_off !== 17) begin bad++; $display("FAIL ignore_busy_fall: got %0d want 17", w_end_off); end
        b0 = busy_tot;
        tick(12);
        total++; if (busy_tot - b0 !== 0) begin bad++; $display("FAIL ignore_restart: got %0d want 0", busy_tot - b0); end
        release_buttons();
    endtask

    task automatic test_abort();
        int lat;
        N = 8'd10; DIR = 1'b1;
        press_wait(lat);
        watch_move(10, 1'b1, 8, -1);
        total++; if (w_steps !== 3) begin bad++; $display("FAIL abort_steps: got %0d want 3", w_steps); end
        total++; if (w_done !== 0) begin bad++; $display("FAIL abort_done: got %0d want 0", w_done); end
        total++; if (w_end_off !== 14) begin bad++; $display("FAIL abort_busy_fall: got %0d want 14", w_end_off); end
        total++; if (REMAIN !== 8'd7) begin bad++; $display("FAIL abort_remain: got %0d want 7", REMAIN); end
        release_buttons();
    endtask

    task automatic test_stop_collision();
        int lat;
        N = 8'd6; DIR = 1'b1;
        press_wait(lat);
        watch_move(6, 1'b1, 2, -1);
        total++; if (w_steps !== 1) begin bad++; $display("FAIL collide_steps: got %0d want 1", w_steps); end
        total++; if (w_end_off !== 8) begin bad++; $display("FAIL collide_busy_fall: got %0d want 8", w_end_off); end
        total++; if (REMAIN !== 8'd5) begin bad++; $display("FAIL collide_remain: got %0d want 5", REMAIN); end
        total++; if (w_done !== 0) begin bad++; $display("FAIL collide_done: got %0d want 0", w_done); end
        release_buttons();
    endtask

    task automatic test_start_with_stop();
        int d0, b0;
        STOP = 1'b1;
        tick(8);
        N = 8'd3;
        d0 = done_tot; b0 = busy_tot;
        START = 1'b1;
        tick(12);
        total++; if (busy_tot - b0 !== 0) begin bad++; $display("FAIL stopheld_busy: got %0d want 0", busy_tot - b0); end
        total++; if (done_tot - d0 !== 0) begin bad++; $display("FAIL stopheld_done: got %0d want 0", done_tot - d0); end
        release_buttons();
    endtask

    task automatic test_mid_move_reset();
        int lat, b0;
        N = 8'd8; DIR = 1'b0;
        press_wait(lat);
        tick(5);
        total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL mreset_busy_before: got %b want 1", BUSY); end
        CR = 1'b0;
        #1;
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL mreset_busy: got %b want 0", BUSY); end
        total++; if (M !== 1'b1) begin bad++; $display("FAIL mreset_m: got %b want 1", M); end
        total++; if (REMAIN !== 8'd0) begin bad++; $display("FAIL mreset_remain: got %0d want 0", REMAIN); end
        total++; if (STEP !== 1'b0 || DONE !== 1'b0) begin bad++; $display("FAIL mreset_strobes: got step=%b done=%b want 0 0", STEP, DONE); end
        tick(1);
        CR = 1'b1;
        b0 = busy_tot;
        tick(15);
        total++; if (busy_tot - b0 !== 0) begin bad++; $display("FAIL mreset_held_start: got %0d busy cycles want 0", busy_tot - b0); end
        START = 1'b0;
        tick(10);
        press_wait(lat);
        total++; if (lat !== START_LAT) begin bad++; $display("FAIL mreset_repress: got %0d want %0d", lat, START_LAT); end
        watch_move(8, 1'b0, -1, -1);
        total++; if (w_steps !== 8) begin bad++; $display("FAIL mreset_steps: got %0d want 8", w_steps); end
        release_buttons();
    endtask

    task automatic test_no_stray_step();
        total++; if (stray_step !== 0) begin bad++; $display("FAIL stray_step: got %0d want 0", stray_step); end
    endtask

    initial begin
        test_reset();
        test_normal_move();
        test_reverse_move();
        test_zero_count();
        test_bounce();
        test_ignore_in_run();
        test_abort();
        test_stop_collision();
        test_start_with_stop();
        test_mid_move_reset();
        test_no_stray_step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/step_cmd_gen.md
# step_cmd_gen

Step command generator placed directly upstream of the stepper-motor pulse distributor. It debounces front-panel START/STOP buttons and latches a requested step count and direction. It then emits exactly that many evenly spaced single-cycle step strobes plus a stable direction level (`M`) for the distributor to consume. The block replaces free-running stepping with counted, abortable moves.

## Interface
- `STEP_DIV`, default 50_000_000: CP cycles between consecutive step strobes (1 step/s at 50 MHz); legal range ≥2.
- `DEB_CYC`, default 1_000_000: consecutive stable samples required to accept a button level (20 ms at 50 MHz); legal range ≥1.
- `CNT_W`, default 8: width of the step count.
- `CP`, input, 1: system clock; all logic is in this single clock domain.
- `CR`, input, 1: reset, asynchronous, active-low.
- `START`, input, 1: raw START button, active-high, asynchronous to CP.
- `STOP`, input, 1: raw STOP button, active-high, asynchronous to CP.
- `DIR`, input, 1: requested direction; 1 = forward, 0 = reverse; sampled at move start.
- `N`, input, CNT_W: requested step count; sampled at move start.
- `STEP`, output, 1: one-CP-cycle advance strobe to the distributor.
- `M`, output, 1: latched direction to the distributor; constant for the whole move.
- `BUSY`, output, 1: high while a move is in progress.
- `DONE`, output, 1: one-cycle pulse when a move completes normally.
- `REMAIN`, output, CNT_W: steps still to issue.

## Operation
- Each button path is a 2-FF synchronizer followed by a debouncer. The debounced level changes only after DEB_CYC consecutive equal synchronized samples. Rising-edge detection on the debounced level yields `start_ev`. `stop_lv` is the debounced STOP level.
- The FSM has two states, IDLE and RUN.
- IDLE:
  - On `start_ev` with `stop_lv`=0 and N≠0: latch `M`<=DIR and `REMAIN`<=N, clear the prescaler, go to RUN.
  - On `start_ev` with N=0: pulse DONE, stay in IDLE.
- RUN:
  - The prescaler counts 0..STEP_DIV-1.
  - At terminal count: assert STEP for that one cycle, decrement REMAIN, reset the prescaler.
  - If REMAIN decrements to 0: pulse DONE in the same cycle as the last STEP and go to IDLE.
- Abort: `stop_lv`=1 in RUN forces IDLE on the next edge. No STEP or DONE is issued; REMAIN holds the unissued count.
- `start_ev` during RUN is ignored. Changes on DIR or N during RUN are ignored.
- Simultaneous events:
  - STOP and terminal count in the same cycle: STOP wins; no STEP, REMAIN is not decremented.
  - `start_ev` together with `stop_lv`=1 in IDLE: no move starts.
- Reset (CR low, at any time including mid-move): state=IDLE, prescaler=0, debouncers cleared to level 0, STEP=0, DONE=0, BUSY=0, M=1, REMAIN=0. After release, no spurious `start_ev` occurs even if START is held high; a fresh press (low then high) is required.

## Timing
- All outputs are registered.
- BUSY rises 1 cycle after `start_ev` is registered.
- The first STEP occurs STEP_DIV cycles after BUSY rises. Subsequent STEPs are exactly STEP_DIV cycles apart.
- The last STEP and the DONE pulse are coincident. BUSY falls on the following cycle.
- Button latency from raw edge to `start_ev` is 2 + DEB_CYC cycles, ±1.
- Total move length is N·STEP_DIV cycles from BUSY rise to the last STEP.
- STEP is never asserted while BUSY=0.

## Structure
- Shared include holds the FSM state localparams (IDLE, RUN) and the default STEP_DIV/DEB_CYC values. Both the distributor and this block derive timing from one CLK_HZ constant.
- One sub-module, `btn_debounce` (synchronizer, debounce counter, debounced level out), is instantiated twice.
- The prescaler is sized $clog2(STEP_DIV).

## Test plan
All scenarios use STEP_DIV=4, DEB_CYC=3, CNT_W=8.
- Normal move: N=5, DIR=1, press START → BUSY high; exactly 5 STEPs spaced 4 cycles; REMAIN 5→0; M=1 throughout; DONE coincides with the 5th STEP; BUSY falls one cycle later.
- Zero count: N=0, press START → single DONE pulse; no STEP; BUSY stays 0.
- Abort: N=10, press STOP after the 3rd STEP → no further STEP; no DONE; BUSY=0; REMAIN=7.
- Bounce and ignore: START toggled with glitches of 2 cycles → no move. During RUN, change DIR and N and press START again → M and step total unchanged.
- STOP/terminal collision: assert debounced STOP on the cycle of the 2nd terminal count → no 2nd STEP; REMAIN=N-1.
- Mid-move reset: pull CR low during RUN while START is held → all outputs at reset values immediately. After CR release, no move starts until START is released and pressed again.
